// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and the packed timing bundle carried through
// the render pipeline.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic HSYNC_POL_DEF = 1'b0;
  localparam logic VSYNC_POL_DEF = 1'b0;

  localparam int HCOUNT_WIDTH = 10;
  localparam int VCOUNT_WIDTH = 10;

  typedef struct packed {
    logic [HCOUNT_WIDTH-1:0] hcount;
    logic [VCOUNT_WIDTH-1:0] vcount;
    logic                    hsync;
    logic                    vsync;
    logic                    blank;
    logic                    line_start;
    logic                    frame_start;
  } vga_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Shared VGA timing bundle: the timing generator drives the master side,
// render blocks consume the slave side.
interface vga_if
  import vga_timing_gen_pkg::*;
#(
  parameter int FRAME_CNT_W = 16
) ();

  logic [HCOUNT_WIDTH-1:0] hcount_out;
  logic [VCOUNT_WIDTH-1:0] vcount_out;
  logic                    hsync_out;
  logic                    vsync_out;
  logic                    blank_out;
  logic                    line_start_out;
  logic                    frame_start_out;
  logic [FRAME_CNT_W-1:0]  frame_count_out;

  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
           line_start_out, frame_start_out, frame_count_out
  );

  modport slave (
    input hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
          line_start_out, frame_start_out, frame_count_out
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Clock-enabled register chain of DEPTH stages with async active-low reset
// to RST_VAL; DEPTH=0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned          DEPTH   = 2,
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_en};
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
      end else if (i_en) begin
        r_stage[0] <= i_d;
        for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel counters, registered sync/blank
// decode, frame counter, and an enable-gated output delay line.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_DEF,
  parameter int          H_FP        = H_FP_DEF,
  parameter int          H_SYNC      = H_SYNC_DEF,
  parameter int          H_BP        = H_BP_DEF,
  parameter int          V_ACTIVE    = V_ACTIVE_DEF,
  parameter int          V_FP        = V_FP_DEF,
  parameter int          V_SYNC      = V_SYNC_DEF,
  parameter int          V_BP        = V_BP_DEF,
  parameter logic        HSYNC_POL   = HSYNC_POL_DEF,
  parameter logic        VSYNC_POL   = VSYNC_POL_DEF,
  parameter int unsigned PIPE_DELAY  = 2,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic pix_en_in,
  vga_if.master vga
);

  localparam int H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam int PAY_W      = $bits(vga_t) + FRAME_CNT_W;

  localparam vga_t RST_TIMING = '{
    hcount: '0, vcount: '0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL,
    blank: 1'b0, line_start: 1'b1, frame_start: 1'b1
  };
  localparam logic [PAY_W-1:0] RST_PAY = {{FRAME_CNT_W{1'b0}}, RST_TIMING};

  if (H_TOT > 2**HCOUNT_WIDTH || V_TOT > 2**VCOUNT_WIDTH || PIPE_DELAY > 15) begin : g_bad_cfg
    $error("vga_timing_gen: totals exceed counter width or PIPE_DELAY > 15");
  end

  vga_t                   r_s0;
  vga_t                   w_s0_next;
  logic [FRAME_CNT_W-1:0] r_fcount;
  logic [FRAME_CNT_W-1:0] w_fcount_next;
  logic                   w_h_last;
  logic                   w_v_last;

  // Decode is taken from the next counter value so that the registered
  // sync/blank flags line up with the registered position.
  always_comb begin
    w_s0_next     = r_s0;
    w_fcount_next = r_fcount;
    w_h_last      = (int'(r_s0.hcount) == H_TOT - 1);
    w_v_last      = (int'(r_s0.vcount) == V_TOT - 1);

    w_s0_next.hcount = w_h_last ? '0 : r_s0.hcount + 1'b1;
    if (w_h_last) w_s0_next.vcount = w_v_last ? '0 : r_s0.vcount + 1'b1;

    w_s0_next.blank = (int'(w_s0_next.hcount) >= H_ACTIVE) ||
                      (int'(w_s0_next.vcount) >= V_ACTIVE);
    w_s0_next.hsync = (int'(w_s0_next.hcount) >= H_SYNC_BEG &&
                       int'(w_s0_next.hcount) <  H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
    w_s0_next.vsync = (int'(w_s0_next.vcount) >= V_SYNC_BEG &&
                       int'(w_s0_next.vcount) <  V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
    w_s0_next.line_start  = (w_s0_next.hcount == '0);
    w_s0_next.frame_start = w_s0_next.line_start && (w_s0_next.vcount == '0);

    if (w_h_last && w_v_last) w_fcount_next = r_fcount + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s0     <= RST_TIMING;
      r_fcount <= '0;
    end else if (pix_en_in) begin
      r_s0     <= w_s0_next;
      r_fcount <= w_fcount_next;
    end
  end

  // Frame count rides the delay line with the timing so it stays aligned
  // with the delayed frame_start.
  logic [PAY_W-1:0]       w_pay_q;
  vga_t                   w_vga;
  logic [FRAME_CNT_W-1:0] w_fc;

  vga_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   (PAY_W),
    .RST_VAL (RST_PAY)
  ) u_delay (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .i_en  (pix_en_in),
    .i_d   ({r_fcount, r_s0}),
    .o_q   (w_pay_q)
  );

  assign {w_fc, w_vga} = w_pay_q;

  assign vga.hcount_out      = w_vga.hcount;
  assign vga.vcount_out      = w_vga.vcount;
  assign vga.hsync_out       = w_vga.hsync;
  assign vga.vsync_out       = w_vga.vsync;
  assign vga.blank_out       = w_vga.blank;
  assign vga.line_start_out  = w_vga.line_start;
  assign vga.frame_start_out = w_vga.frame_start;
  assign vga.frame_count_out = w_fc;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator. Produces the hcount/vcount/hsync/vsync/blank bundle consumed by the board renderer, cursor overlay and statistics graph.
- Successor to the fixed 640x480 timing. Adds:
  - generic resolution and porch widths, with selectable sync polarity;
  - a pixel clock-enable;
  - a configurable output delay line that aligns timing with board-memory read latency;
  - frame and line strobes and a frame counter.
- Sits between the clock domain top level and all render blocks. It drives the src side of the shared vga interface.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- PIPE_DELAY, 2, extra register stages on all timing outputs (0..15)
- FRAME_CNT_W, 16, frame counter width

Ports:
- clk_in  input  1  system/pixel clock
- rst_n_in  input  1  asynchronous active-low reset
- pix_en_in  input  1  pixel-rate clock enable; counters advance only when high
- hcount_out  output  HCOUNT_WIDTH  delayed horizontal position
- vcount_out  output  VCOUNT_WIDTH  delayed vertical position
- hsync_out  output  1  delayed hsync
- vsync_out  output  1  delayed vsync
- blank_out  output  1  delayed blank; 1 outside the active area
- line_start_out  output  1  one-pixel pulse, aligned with delayed hcount==0
- frame_start_out  output  1  one-pixel pulse, aligned with delayed hcount==0 && vcount==0
- frame_count_out  output  FRAME_CNT_W  frames completed since reset

Behaviour:
- Clock and reset: single clock clk_in. Reset is asynchronous and active-low on rst_n_in; it clears every register, including all delay stages.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
- Elaboration check: fail if H_TOTAL > 2**HCOUNT_WIDTH, V_TOTAL > 2**VCOUNT_WIDTH, or PIPE_DELAY > 15.
- Core counters (stage 0):
  - h increments when pix_en_in=1. At h==H_TOTAL-1 it wraps to 0 and v increments; at v==V_TOTAL-1 v wraps to 0.
  - When pix_en_in=0, all stages hold, including the delay line. The delay line is clock-enabled by pix_en_in.
- Stage-0 decode (registered, from the counter values):
  - blank = (h >= H_ACTIVE) || (v >= V_ACTIVE)
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else !HSYNC_POL
  - vsync = VSYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else !VSYNC_POL
  - vsync changes on the same pixel as the v update, i.e. at h=0.
- Latency: outputs are stage-0 values delayed by PIPE_DELAY enabled cycles. With PIPE_DELAY=0 the outputs come directly from the stage-0 registers.
- Reset values of all outputs:
  - hcount 0, vcount 0, blank 0, hsync !HSYNC_POL, vsync !VSYNC_POL
  - line_start 1, frame_start 1; position (0,0) is the first pixel after reset
  - frame_count 0
- All delay stages reset to the (0,0) values above. The first PIPE_DELAY enabled cycles therefore repeat pixel (0,0); this is accepted.
- frame_count_out:
  - increments by 1, modulo 2**FRAME_CNT_W, when the delayed position reaches (0,0) after a wrap, so it is aligned with frame_start_out;
  - does not increment on the reset pixel.
- Reset mid-frame: all state immediately returns to the reset values; there is no partial-frame recovery.

Decomposition:
- Shared package (common header): H_*/V_* defaults, HCOUNT_WIDTH, VCOUNT_WIDTH, the vga_t struct and the vga_if interface.
- New constants added to the package: H_TOTAL, V_TOTAL and the sync polarity defaults.
- One sub-module: vga_delay_line. It holds a parametrised DEPTH/width register chain with an enable and async active-low reset, and is reusable by the render pipeline.

Test Plan:
- Defaults, pix_en_in tied to 1, PIPE_DELAY=0: 420000 cycles between successive frame_start_out pulses. hsync low for 96 cycles starting at hcount=656. vsync low for 2 lines at vcount 490-491.
- Small params (H 8/1/2/1, V 4/1/1/1, PIPE_DELAY=3): hcount/vcount sequence equals the undelayed model shifted 3 cycles. blank high exactly at h>=8 or v>=4.
- pix_en_in toggling 1,0,1,0: counters advance once per two clocks. Outputs hold during low cycles. Frame period doubles to 2*H_TOTAL*V_TOTAL.
- HSYNC_POL=1, VSYNC_POL=1: sync pulses inverted, with the same positions and widths as the default run.
- Assert rst_n_in low asynchronously mid-line at h=300, v=200: all outputs take reset values without waiting for a clock edge. After release the first frame_start_out has frame_count_out=0; the next has 1.
- FRAME_CNT_W=2, run 5 frames: frame_count_out sequence 1,2,3,0,1.
